// File: rtl/dp_pkg.sv
// ============================================================
// Package : dp_pkg
// Brief   : Op codes and FSM state encoding for dp_op_arbiter.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

package dp_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        OP_INC = 2'd0,
        OP_INV = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dp_op_arbiter_if.sv
// ============================================================
// Module  : dp_op_arbiter_if
// Brief   : Request/response handshake bundle for dp_op_arbiter.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

interface dp_op_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_op0;
    logic [1:0]           req_op1;
    logic [WIDTH-1:0]     req_data0;
    logic [WIDTH-1:0]     req_data1;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_id;
    logic [WIDTH-1:0]     resp_data;
    logic                 resp_carry;
    logic [CNT_WIDTH-1:0] ops_done;

    modport master (
        output req_valid, req_op0, req_op1, req_data0, req_data1, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_carry, ops_done
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_carry, ops_done
    );
endinterface

`default_nettype wire

// File: rtl/dp_alu.sv
// ============================================================
// Module  : dp_alu
// Brief   : Combinational shared datapath: INC / INV / ACC / CLR.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

module dp_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] acc_next_o
);
    logic [WIDTH:0] inc_sum;
    logic [WIDTH:0] acc_sum;

    assign inc_sum = {1'b0, data_i} + {{WIDTH{1'b0}}, 1'b1};
    assign acc_sum = {1'b0, acc_i} + {1'b0, data_i};

    always_comb begin
        result_o   = '0;
        carry_o    = 1'b0;
        acc_next_o = acc_i;
        case (op_i)
            OP_INC: begin
                result_o = inc_sum[WIDTH-1:0];
                carry_o  = inc_sum[WIDTH];
            end
            OP_INV: result_o = ~data_i;
            OP_ACC: begin
                result_o   = acc_sum[WIDTH-1:0];
                carry_o    = acc_sum[WIDTH];
                acc_next_o = acc_sum[WIDTH-1:0];
            end
            OP_CLR: begin
                // CLR reports the accumulator value it destroys
                result_o   = acc_i;
                acc_next_o = '0;
            end
            default: result_o = '0;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/dp_op_arbiter.sv
// ============================================================
// Module  : dp_op_arbiter
// Brief   : Two-requester round-robin arbiter sharing one dp_alu.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

module dp_op_arbiter
    import dp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    dp_op_arbiter_if.slave bus
);
    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     resp_data_q, resp_data_d;
    logic                 resp_carry_q, resp_carry_d;
    logic                 resp_id_q, resp_id_d;
    logic [CNT_WIDTH-1:0] ops_done_q, ops_done_d;

    logic                 any_valid;
    logic                 grant;
    logic [1:0]           ready;
    op_e                  alu_op;
    logic [WIDTH-1:0]     alu_data;
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_carry;
    logic [WIDTH-1:0]     alu_acc_next;

    // On contention the requester that did not win last time is served
    assign any_valid = |bus.req_valid;
    assign grant     = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    assign alu_op    = op_e'(grant ? bus.req_op1 : bus.req_op0);
    assign alu_data  = grant ? bus.req_data1 : bus.req_data0;

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i       (alu_op),
        .data_i     (alu_data),
        .acc_i      (acc_q),
        .result_o   (alu_result),
        .carry_o    (alu_carry),
        .acc_next_o (alu_acc_next)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        acc_d        = acc_q;
        resp_data_d  = resp_data_q;
        resp_carry_d = resp_carry_q;
        resp_id_d    = resp_id_q;
        ops_done_d   = ops_done_q;
        ready        = 2'b00;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    ready        = grant ? 2'b10 : 2'b01;
                    state_d      = RESP;
                    last_grant_d = grant;
                    acc_d        = alu_acc_next;
                    resp_data_d  = alu_result;
                    resp_carry_d = alu_carry;
                    resp_id_d    = grant;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d    = IDLE;
                    ops_done_d = ops_done_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            acc_q        <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
            resp_id_q    <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            acc_q        <= acc_d;
            resp_data_q  <= resp_data_d;
            resp_carry_q <= resp_carry_d;
            resp_id_q    <= resp_id_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_carry = resp_carry_q;
    assign bus.ops_done   = ops_done_q;
endmodule

`default_nettype wire
